// File: rtl/inst_loader.sv
// Program loader: takes a byte stream (16-bit word count, big-endian
// 32-bit words, XOR checksum byte), writes the words into instruction
// memory at consecutive addresses, and holds the CPU in reset until the
// image has been loaded and its checksum verified.
module inst_loader #(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
        CHK,
        DONE,
        ERR
    } state_t;

    state_t      state;
    logic [7:0]  cnt_hi;     // header MSB, held until the LSB arrives
    logic [15:0] word_cnt;   // number of words announced by the header
    logic [15:0] word_idx;   // index of the word currently being assembled
    logic [1:0]  byte_idx;   // byte position within the current word
    logic [23:0] word_sr;    // first three bytes of the current word
    logic [7:0]  chk;        // running XOR of data bytes
    logic        xfer;
    logic [15:0] hdr_n;
    logic        last_word;

    assign xfer      = in_valid & in_ready;
    assign hdr_n     = {cnt_hi, in_data};
    assign last_word = (word_idx + 16'd1) == word_cnt;

    // Load sequencer: state, datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cnt_hi    <= '0;
            word_cnt  <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
            word_sr   <= '0;
            chk       <= '0;
        end else begin
            // write strobe lasts exactly one cycle per word
            mem_we <= 1'b0;

            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state    <= HDR_HI;
                        in_ready <= 1'b1;
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        chk      <= '0;
                        word_idx <= '0;
                        byte_idx <= '0;
                    end
                end

                HDR_HI: begin
                    if (xfer) begin
                        cnt_hi <= in_data;
                        state  <= HDR_LO;
                    end
                end

                HDR_LO: begin
                    if (xfer) begin
                        word_cnt <= hdr_n;
                        if (32'(hdr_n) > DEPTH) begin
                            state    <= ERR;
                            in_ready <= 1'b0;
                            err      <= 1'b1;
                        end else if (hdr_n == 16'd0) begin
                            state <= CHK;
                        end else begin
                            state <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (xfer) begin
                        chk      <= chk ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        word_sr  <= {word_sr[15:0], in_data};
                        if (byte_idx == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= ADDR_W'(BASE_ADDR + 32'(word_idx));
                            mem_wdata <= {word_sr, in_data};
                            word_idx  <= word_idx + 16'd1;
                            if (last_word) begin
                                state <= CHK;
                            end
                        end
                    end
                end

                CHK: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        if (in_data == chk) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    cpu_hold <= 1'b0;
                    done     <= 1'b0;
                    err      <= 1'b0;
                end
            endcase
        end
    end

endmodule
